// File: rtl/ipm_distributed_sfifo_v1_3_ip_fifo_if.sv
// Handshake/status bundle for the distributed-RAM synchronous FIFO.
// master = producer/consumer side, slave = FIFO side.
interface ipm_distributed_sfifo_v1_3_ip_fifo_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/ipm_distributed_sfifo_v1_3_ip_fifo.sv
// Single-clock FIFO on distributed RAM with level, almost flags and optional output register.
// Define IPM_DSFIFO_ERR_FLAG_EN to build the sticky overflow/underflow flags.
module ipm_distributed_sfifo_v1_3_ip_fifo #(
    parameter int unsigned ADDR_WIDTH       = 4,
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned OUT_REG          = 0,
    parameter int unsigned ALMOST_FULL_NUM  = 2**ADDR_WIDTH - 2,
    parameter int unsigned ALMOST_EMPTY_NUM = 2
) (
    input  logic clk,
    input  logic rst,
    ipm_distributed_sfifo_v1_3_ip_fifo_if.slave bus
);
    localparam int unsigned Depth = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FullLvl = Depth[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AfLvl   = ALMOST_FULL_NUM[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AeLvl   = ALMOST_EMPTY_NUM[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic full_q, empty_q, afull_q, aempty_q;
    logic wr_accept, rd_accept;

    // Acceptance uses registered flags only, so a full/empty FIFO never passes through.
    assign wr_accept = bus.wr_en && !full_q;
    assign rd_accept = bus.rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_accept) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (rd_accept) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        if (wr_accept && !rd_accept) level_d = level_q + (ADDR_WIDTH+1)'(1);
        if (rd_accept && !wr_accept) level_d = level_q - (ADDR_WIDTH+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == FullLvl);
            empty_q  <= (level_d == '0);
            afull_q  <= (level_d >= AfLvl);
            aempty_q <= (level_d <= AeLvl);
        end
    end

    // Storage has no reset so it maps onto LUT RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) mem_q[wr_ptr_q] <= bus.wr_data;
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] rd_data_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)            rd_data_q <= '0;
                else if (rd_accept) rd_data_q <= mem_q[rd_ptr_q];
            end
            assign bus.rd_data = rd_data_q;
        end else begin : g_show_ahead
            assign bus.rd_data = mem_q[rd_ptr_q];
        end
    endgenerate

`ifdef IPM_DSFIFO_ERR_FLAG_EN
    logic overflow_q, underflow_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en && full_q)  overflow_q  <= 1'b1;
            if (bus.rd_en && empty_q) underflow_q <= 1'b1;
        end
    end
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.level        = level_q;
endmodule

// File: tb/tb_ipm_distributed_sfifo_v1_3_ip_fifo.sv
// Directed bench: show-ahead instance for fill/drain/streaming, registered-output instance
// for read latency and asynchronous reset of rd_data.
module tb_ipm_distributed_sfifo_v1_3_ip_fifo;
`ifdef IPM_DSFIFO_ERR_FLAG_EN
    localparam logic ErrEn = 1'b1;
`else
    localparam logic ErrEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst1 = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ipm_distributed_sfifo_v1_3_ip_fifo_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) if0 ();
    ipm_distributed_sfifo_v1_3_ip_fifo_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) if1 ();

    ipm_distributed_sfifo_v1_3_ip_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .OUT_REG(0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    ipm_distributed_sfifo_v1_3_ip_fifo #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .OUT_REG(1)) u_dut_reg (
        .clk (clk),
        .rst (rst1),
        .bus (if1.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        if0.wr_en = 1'b0; if0.rd_en = 1'b0; if0.wr_data = '0;
        if1.wr_en = 1'b0; if1.rd_en = 1'b0; if1.wr_data = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_empty", 32'(if0.empty), 1);
        check("rst_full", 32'(if0.full), 0);
        check("rst_ae", 32'(if0.almost_empty), 1);
        check("rst_af", 32'(if0.almost_full), 0);
        check("rst_level", 32'(if0.level), 0);
        check("rst_ovf", 32'(if0.overflow), 0);
        check("rst_udf", 32'(if0.underflow), 0);

        // Fill with 1..16.
        if0.wr_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if0.wr_data = 16'(i);
            tick();
            check("fill_level", 32'(if0.level), 32'(i));
            check("fill_full", 32'(if0.full), 32'(i == 16));
            check("fill_af", 32'(if0.almost_full), 32'(i >= 14));
            check("fill_ae", 32'(if0.almost_empty), 32'(i <= 2));
            check("fill_empty", 32'(if0.empty), 0);
            check("fill_head", 32'(if0.rd_data), 32'h0001);
        end
        if0.wr_data = 16'h0011;
        tick();
        check("ovf_level", 32'(if0.level), 16);
        check("ovf_flag", 32'(if0.overflow), 32'(ErrEn));
        if0.wr_en = 1'b0;

        // Drain in order.
        if0.rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            check("drain_data", 32'(if0.rd_data), 32'(i));
            tick();
            check("drain_level", 32'(if0.level), 32'(16 - i));
            check("drain_empty", 32'(if0.empty), 32'(i == 16));
            check("drain_ae", 32'(if0.almost_empty), 32'((16 - i) <= 2));
            check("drain_full", 32'(if0.full), 0);
        end
        tick();
        check("udf_level", 32'(if0.level), 0);
        check("udf_flag", 32'(if0.underflow), 32'(ErrEn));
        if0.rd_en = 1'b0;

        // Level 8, then streaming read+write for 40 cycles.
        if0.wr_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if0.wr_data = 16'(16'h0100 + k);
            tick();
        end
        check("l8_level", 32'(if0.level), 8);
        if0.rd_en = 1'b1;
        for (int j = 0; j < 40; j++) begin
            if0.wr_data = 16'(16'h0108 + j);
            check("stream_data", 32'(if0.rd_data), 32'(16'h0100 + j));
            tick();
            check("stream_level", 32'(if0.level), 8);
        end
        if0.rd_en = 1'b0;

        // Queue holds 0x128..0x12F; top up to full.
        for (int k = 0; k < 8; k++) begin
            if0.wr_data = 16'(16'h0200 + k);
            tick();
        end
        check("top_full", 32'(if0.full), 1);
        check("top_head", 32'(if0.rd_data), 32'h0128);
        if0.wr_data = 16'hDEAD;
        if0.rd_en = 1'b1;
        tick();
        if0.wr_en = 1'b0;
        if0.rd_en = 1'b0;
        check("rw_full_level", 32'(if0.level), 15);
        check("rw_full_full", 32'(if0.full), 0);
        check("rw_full_af", 32'(if0.almost_full), 1);
        check("rw_full_ovf", 32'(if0.overflow), 32'(ErrEn));
        check("rw_full_head", 32'(if0.rd_data), 32'h0129);

        // Asynchronous reset mid-stream, then write on first edge with rst low.
        rst = 1'b1;
        #2;
        check("arst_empty", 32'(if0.empty), 1);
        check("arst_level", 32'(if0.level), 0);
        check("arst_full", 32'(if0.full), 0);
        check("arst_ovf", 32'(if0.overflow), 0);
        if0.wr_en = 1'b1;
        if0.wr_data = 16'h0077;
        tick();
        check("arst_hold_level", 32'(if0.level), 0);
        rst = 1'b0;
        tick();
        if0.wr_en = 1'b0;
        check("post_rst_level", 32'(if0.level), 1);
        check("post_rst_head", 32'(if0.rd_data), 32'h0077);
        check("post_rst_empty", 32'(if0.empty), 0);

        // Registered-output instance.
        rst1 = 1'b0;
        #1;
        check("r_rst_data", 32'(if1.rd_data), 0);
        if1.wr_en = 1'b1;
        if1.wr_data = 16'hA5A5;
        tick();
        check("r_wr1_data", 32'(if1.rd_data), 0);
        check("r_wr1_empty", 32'(if1.empty), 0);
        if1.wr_data = 16'h5A5A;
        tick();
        if1.wr_en = 1'b0;
        check("r_wr2_data", 32'(if1.rd_data), 0);
        tick();
        check("r_idle_data", 32'(if1.rd_data), 0);
        if1.rd_en = 1'b1;
        tick();
        if1.rd_en = 1'b0;
        check("r_pop_data", 32'(if1.rd_data), 32'hA5A5);
        check("r_pop_level", 32'(if1.level), 1);
        tick(); tick();
        check("r_hold_data", 32'(if1.rd_data), 32'hA5A5);
        rst1 = 1'b1;
        #2;
        check("r_arst_data", 32'(if1.rd_data), 0);
        check("r_arst_empty", 32'(if1.empty), 1);
        check("r_arst_level", 32'(if1.level), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
